// File: rtl/lane_phase_arbiter.sv
// lane_phase_arbiter: demand/night arbitration with emergency preemption, pedestrian walk and green/yellow/all-red timing
module lane_phase_arbiter #(
  parameter int GREEN_DAY   = 20,
  parameter int GREEN_NIGHT = 10,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 2,
  parameter int PED_T       = 8,
  parameter int EMG_HOLD    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hoursIn,
  input  logic        pedSignal,
  input  logic        emgSignal,
  input  logic [7:0]  emgLane,
  input  logic [63:0] lanes,
  output logic [7:0]  greenMask,
  output logic [7:0]  yellowMask,
  output logic [7:0]  walkMask,
  output logic [1:0]  trafficMode,
  output logic [1:0]  phase,
  output logic [7:0]  currentCount
);
  typedef enum logic [2:0] {S_ALLRED, S_GREEN, S_YELLOW, S_PED, S_EMG} state_t;
  localparam logic [7:0] T_GREEN_DAY   = 8'(GREEN_DAY - 1);
  localparam logic [7:0] T_GREEN_NIGHT = 8'(GREEN_NIGHT - 1);
  localparam logic [7:0] T_YELLOW      = 8'(YELLOW_T - 1);
  localparam logic [7:0] T_ALLRED      = 8'(ALLRED_T - 1);
  localparam logic [7:0] T_PED         = 8'(PED_T - 1);
  localparam logic [7:0] T_EMG         = 8'(EMG_HOLD - 1);
  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d, load;
  logic [1:0]  phase_q, phase_d;
  logic        ped_q, ped_d;
  logic [7:0]  green_d, yellow_d, walk_d;
  logic [1:0]  mode_d;
  logic        night, emg_req, done;
  logic [1:0]  emg_ap, arb, c1, c2, c3, b12;
  logic [8:0]  dem [4];
  function automatic logic [7:0] ap_mask(input logic [1:0] a);
    return 8'hC0 >> {a, 1'b0};
  endfunction
  for (genvar i = 0; i < 4; i++) begin : g_dem
    assign dem[i] = 9'(lanes[63-16*i -: 8]) + 9'(lanes[55-16*i -: 8]);
  end
  assign night   = hoursIn < 5'd6 || hoursIn >= 5'd20;
  assign emg_req = emgSignal && |emgLane;
  assign done    = timer_q == 8'd0;
  assign emg_ap  = |emgLane[7:6] ? 2'd0 : |emgLane[5:4] ? 2'd1 : |emgLane[3:2] ? 2'd2 : 2'd3;
  assign c1      = phase_q + 2'd1;
  assign c2      = phase_q + 2'd2;
  assign c3      = phase_q + 2'd3;
  always_comb begin
    b12 = dem[c2] > dem[c1] ? c2 : c1;
    arb = night ? c1 : dem[c3] > dem[b12] ? c3 : b12;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_ALLRED;
      timer_q     <= T_ALLRED;
      phase_q     <= 2'd3;
      ped_q       <= 1'b0;
      greenMask   <= 8'h00;
      yellowMask  <= 8'h00;
      walkMask    <= 8'h00;
      trafficMode <= 2'b00;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      phase_q     <= phase_d;
      ped_q       <= ped_d;
      greenMask   <= green_d;
      yellowMask  <= yellow_d;
      walkMask    <= walk_d;
      trafficMode <= mode_d;
    end
  end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ped_d   = ped_q | pedSignal;
    case (state_q)
      S_GREEN:  if (emg_req) state_d = emg_ap == phase_q ? S_EMG : S_YELLOW;
                else if (done) state_d = S_YELLOW;
      S_YELLOW: if (done) state_d = S_ALLRED;
      S_ALLRED: if (done) begin
                  if (emg_req) begin
                    state_d = S_EMG;
                    phase_d = emg_ap;
                  end else if (ped_q) state_d = S_PED;
                  else begin
                    state_d = S_GREEN;
                    phase_d = arb;
                  end
                end
      S_PED:    if (emg_req) begin
                  state_d = S_ALLRED;
                  ped_d   = 1'b1;
                end else if (done) state_d = S_ALLRED;
      S_EMG:    if (emg_req ? emg_ap != phase_q : done) state_d = S_YELLOW;
      default:  state_d = S_ALLRED;
    endcase
    if (state_d == S_PED && state_q != S_PED) ped_d = pedSignal;
    load = state_d == S_GREEN  ? (night ? T_GREEN_NIGHT : T_GREEN_DAY) :
           state_d == S_YELLOW ? T_YELLOW :
           state_d == S_PED    ? T_PED :
           state_d == S_EMG    ? T_EMG : T_ALLRED;
    timer_d = state_d != state_q ? load :
              (state_q == S_EMG && emg_req) ? T_EMG : timer_q - 8'd1;
  end
  always_comb begin
    green_d  = (state_d == S_GREEN || state_d == S_EMG) ? ap_mask(phase_d) : 8'h00;
    yellow_d = state_d == S_YELLOW ? ap_mask(phase_d) : 8'h00;
    walk_d   = state_d == S_PED ? 8'hFF : 8'h00;
    mode_d   = state_d == S_EMG ? 2'b10 : state_d == S_PED ? 2'b11 : {1'b0, night};
  end
  assign phase        = phase_q;
  assign currentCount = timer_q;
endmodule

// File: tb/tb_lane_phase_arbiter.sv
// tb_lane_phase_arbiter: directed vector table, hand sequences and random run against a behavioural model
module tb_lane_phase_arbiter;
  localparam int GD = 20, GN = 10, YT = 3, AT = 2, PT = 8, EH = 4;
  localparam int AR = 0, GR = 1, YE = 2, PD = 3, EM = 4;
  localparam logic [63:0] L0 = 64'h0;
  localparam logic [63:0] LD = 64'h0000_7F00_0000_0700;
  localparam logic [63:0] LT = 64'h0000_0000_0500_0500;
  localparam logic [63:0] LN = 64'h0000_FF00_0000_0000;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hoursIn;
  logic        pedSignal, emgSignal;
  logic [7:0]  emgLane;
  logic [63:0] lanes;
  logic [7:0]  greenMask, yellowMask, walkMask, currentCount;
  logic [1:0]  trafficMode, phase;
  int n_chk = 0;
  int n_fail = 0;
  int m_st, m_len, m_age, m_ph;
  logic m_ped, m_valid = 1'b0;
  typedef struct {
    logic r; logic [4:0] h; logic p, e; logic [7:0] el; logic [63:0] ln; int n;
    logic [7:0] g, y, w; logic [1:0] md; logic [7:0] c;
  } vec_t;
  vec_t tbl[$];
  lane_phase_arbiter #(.GREEN_DAY(GD), .GREEN_NIGHT(GN), .YELLOW_T(YT), .ALLRED_T(AT),
                       .PED_T(PT), .EMG_HOLD(EH)) dut (
    .clk(clk), .rst(rst), .hoursIn(hoursIn), .pedSignal(pedSignal), .emgSignal(emgSignal),
    .emgLane(emgLane), .lanes(lanes), .greenMask(greenMask), .yellowMask(yellowMask),
    .walkMask(walkMask), .trafficMode(trafficMode), .phase(phase), .currentCount(currentCount));
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, logic [4:0] h, logic p, logic e, logic [7:0] el, logic [63:0] ln,
                             int n, logic [7:0] g, logic [7:0] y, logic [7:0] w, logic [1:0] md, logic [7:0] c);
    vec_t t;
    t.r = r; t.h = h; t.p = p; t.e = e; t.el = el; t.ln = ln; t.n = n;
    t.g = g; t.y = y; t.w = w; t.md = md; t.c = c;
    return t;
  endfunction
  function automatic logic [7:0] amask(int a);
    return 8'hC0 >> (2 * a);
  endfunction
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic enter(int st, int len);
    m_st = st; m_len = len; m_age = 0;
  endtask
  // Model: each state is a fixed-length interval; age counts up from entry.
  task automatic model_step();
    int ap, best, d[4];
    logic req, last, nt, old_ped;
    if (!rst) begin
      m_valid = 1'b1; m_ph = 3; m_ped = 1'b0;
      enter(AR, AT);
      return;
    end
    if (!m_valid) return;
    nt = hoursIn < 6 || hoursIn >= 20;
    req = emgSignal && emgLane != 0;
    ap = 0;
    for (int b = 0; b < 8; b++) if (emgLane[b]) ap = (7 - b) / 2;
    for (int a = 0; a < 4; a++) d[a] = int'(lanes[63-16*a -: 8]) + int'(lanes[55-16*a -: 8]);
    best = (m_ph + 1) % 4;
    if (!nt)
      for (int k = 2; k < 4; k++) if (d[(m_ph + k) % 4] > d[best]) best = (m_ph + k) % 4;
    last = m_age == m_len - 1;
    old_ped = m_ped;
    m_ped = m_ped | pedSignal;
    case (m_st)
      GR: if (req && ap == m_ph) enter(EM, EH); else if (req || last) enter(YE, YT); else m_age++;
      YE: if (last) enter(AR, AT); else m_age++;
      AR: if (!last) m_age++;
          else if (req) begin m_ph = ap; enter(EM, EH); end
          else if (old_ped) begin enter(PD, PT); m_ped = pedSignal; end
          else begin m_ph = best; enter(GR, nt ? GN : GD); end
      PD: if (req) begin enter(AR, AT); m_ped = 1'b1; end else if (last) enter(AR, AT); else m_age++;
      default: if (req && ap != m_ph) enter(YE, YT);
               else if (req) enter(EM, EH);
               else if (last) enter(YE, YT);
               else m_age++;
    endcase
  endtask
  function automatic logic [1:0] model_mode();
    logic nt;
    nt = hoursIn < 6 || hoursIn >= 20;
    if (!rst) return 2'b00;
    return m_st == EM ? 2'b10 : m_st == PD ? 2'b11 : {1'b0, nt};
  endfunction
  task automatic cycle();
    logic [1:0] md;
    @(posedge clk);
    model_step();
    md = model_mode();
    #1;
    if (m_valid) begin
      chk("m_green", greenMask, (m_st == GR || m_st == EM) ? amask(m_ph) : 8'h00);
      chk("m_yellow", yellowMask, m_st == YE ? amask(m_ph) : 8'h00);
      chk("m_walk", walkMask, m_st == PD ? 8'hFF : 8'h00);
      chk("m_mode", {6'b0, trafficMode}, {6'b0, md});
      chk("m_phase", {6'b0, phase}, 8'(m_ph));
      chk("m_count", currentCount, 8'(m_len - 1 - m_age));
    end
  endtask
  task automatic run(int n);
    repeat (n) cycle();
  endtask
  task automatic expect_out(string nm, logic [7:0] g, logic [7:0] y, logic [7:0] w, logic [1:0] md);
    chk({nm, "_green"}, greenMask, g);
    chk({nm, "_yellow"}, yellowMask, y);
    chk({nm, "_walk"}, walkMask, w);
    chk({nm, "_mode"}, {6'b0, trafficMode}, {6'b0, md});
  endtask
  initial begin
    rst = 1'b0; hoursIn = 5'd12; pedSignal = 1'b0; emgSignal = 1'b0; emgLane = 8'h00; lanes = L0;
    tbl.push_back(v(0, 12, 0, 0, 8'h00, L0,  2, 8'h00, 8'h00, 8'h00, 2'd0, 8'd1));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, L0,  1, 8'h00, 8'h00, 8'h00, 2'd0, 8'd0));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, L0,  1, 8'hC0, 8'h00, 8'h00, 2'd0, 8'd19));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, L0, 19, 8'hC0, 8'h00, 8'h00, 2'd0, 8'd0));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, L0,  1, 8'h00, 8'hC0, 8'h00, 2'd0, 8'd2));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, L0,  2, 8'h00, 8'hC0, 8'h00, 2'd0, 8'd0));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, L0,  1, 8'h00, 8'h00, 8'h00, 2'd0, 8'd1));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, L0,  1, 8'h00, 8'h00, 8'h00, 2'd0, 8'd0));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, L0,  1, 8'h30, 8'h00, 8'h00, 2'd0, 8'd19));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, LD, 25, 8'h03, 8'h00, 8'h00, 2'd0, 8'd19));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, LD, 25, 8'h30, 8'h00, 8'h00, 2'd0, 8'd19));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, LT, 25, 8'h0C, 8'h00, 8'h00, 2'd0, 8'd19));
    tbl.push_back(v(1, 12, 1, 0, 8'h00, LT,  1, 8'h0C, 8'h00, 8'h00, 2'd0, 8'd18));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, LT, 18, 8'h0C, 8'h00, 8'h00, 2'd0, 8'd0));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, LT,  6, 8'h00, 8'h00, 8'hFF, 2'd3, 8'd7));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, LT,  7, 8'h00, 8'h00, 8'hFF, 2'd3, 8'd0));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, LT,  1, 8'h00, 8'h00, 8'h00, 2'd0, 8'd1));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, LT,  2, 8'h03, 8'h00, 8'h00, 2'd0, 8'd19));
    tbl.push_back(v(1, 12, 0, 0, 8'h00, L0, 25, 8'hC0, 8'h00, 8'h00, 2'd0, 8'd19));
    tbl.push_back(v(1, 12, 0, 1, 8'h08, L0,  1, 8'h00, 8'hC0, 8'h00, 2'd0, 8'd2));
    tbl.push_back(v(1, 12, 0, 1, 8'h08, L0,  2, 8'h00, 8'hC0, 8'h00, 2'd0, 8'd0));
    tbl.push_back(v(1, 12, 0, 1, 8'h08, L0,  2, 8'h00, 8'h00, 8'h00, 2'd0, 8'd0));
    tbl.push_back(v(1, 12, 0, 1, 8'h08, L0,  1, 8'h0C, 8'h00, 8'h00, 2'd2, 8'd3));
    tbl.push_back(v(1, 12, 0, 1, 8'h08, L0, 10, 8'h0C, 8'h00, 8'h00, 2'd2, 8'd3));
    tbl.push_back(v(1, 12, 0, 0, 8'h08, L0,  3, 8'h0C, 8'h00, 8'h00, 2'd2, 8'd0));
    tbl.push_back(v(1, 12, 0, 0, 8'h08, L0,  1, 8'h00, 8'h0C, 8'h00, 2'd0, 8'd2));
    tbl.push_back(v(1, 12, 0, 1, 8'h02, L0,  2, 8'h00, 8'h0C, 8'h00, 2'd0, 8'd0));
    tbl.push_back(v(1, 12, 0, 1, 8'h02, L0,  3, 8'h03, 8'h00, 8'h00, 2'd2, 8'd3));
    tbl.push_back(v(0, 12, 0, 1, 8'h02, L0,  1, 8'h00, 8'h00, 8'h00, 2'd0, 8'd1));
    tbl.push_back(v(1, 12, 0, 0, 8'h02, L0,  2, 8'hC0, 8'h00, 8'h00, 2'd0, 8'd19));
    tbl.push_back(v(1, 12, 0, 1, 8'h80, L0,  1, 8'hC0, 8'h00, 8'h00, 2'd2, 8'd3));
    tbl.push_back(v(1, 12, 0, 0, 8'h80, L0,  4, 8'h00, 8'hC0, 8'h00, 2'd0, 8'd2));
    tbl.push_back(v(0, 22, 0, 0, 8'h00, LN,  1, 8'h00, 8'h00, 8'h00, 2'd0, 8'd1));
    tbl.push_back(v(1, 22, 0, 0, 8'h00, LN,  1, 8'h00, 8'h00, 8'h00, 2'd1, 8'd0));
    tbl.push_back(v(1, 22, 0, 0, 8'h00, LN,  1, 8'hC0, 8'h00, 8'h00, 2'd1, 8'd9));
    tbl.push_back(v(1, 22, 0, 0, 8'h00, LN, 15, 8'h30, 8'h00, 8'h00, 2'd1, 8'd9));
    tbl.push_back(v(1, 22, 0, 0, 8'h00, LN, 15, 8'h0C, 8'h00, 8'h00, 2'd1, 8'd9));
    tbl.push_back(v(1, 22, 0, 0, 8'h00, LN, 15, 8'h03, 8'h00, 8'h00, 2'd1, 8'd9));
    tbl.push_back(v(1, 22, 0, 0, 8'h00, LN, 15, 8'hC0, 8'h00, 8'h00, 2'd1, 8'd9));
    foreach (tbl[i]) begin
      rst = tbl[i].r; hoursIn = tbl[i].h; pedSignal = tbl[i].p; emgSignal = tbl[i].e;
      emgLane = tbl[i].el; lanes = tbl[i].ln;
      run(tbl[i].n);
      expect_out($sformatf("v%0d", i), tbl[i].g, tbl[i].y, tbl[i].w, tbl[i].md);
      chk($sformatf("v%0d_count", i), currentCount, tbl[i].c);
    end
    // Simultaneous walk request and emergency, then emergency aborting the walk.
    hoursIn = 5'd12; lanes = L0; pedSignal = 1'b0; emgSignal = 1'b0; emgLane = 8'h00;
    rst = 1'b0; run(1);
    rst = 1'b1; run(2);
    expect_out("h_start", 8'hC0, 8'h00, 8'h00, 2'd0);
    pedSignal = 1'b1; emgSignal = 1'b1; emgLane = 8'h20; run(1);
    expect_out("h_emg_yel", 8'h00, 8'hC0, 8'h00, 2'd0);
    pedSignal = 1'b0; run(4);
    expect_out("h_allred", 8'h00, 8'h00, 8'h00, 2'd0);
    run(1);
    expect_out("h_emg_s", 8'h30, 8'h00, 8'h00, 2'd2);
    emgSignal = 1'b0; run(4);
    expect_out("h_emg_end", 8'h00, 8'h30, 8'h00, 2'd0);
    run(5);
    expect_out("h_ped", 8'h00, 8'h00, 8'hFF, 2'd3);
    emgSignal = 1'b1; emgLane = 8'h01; run(1);
    expect_out("h_ped_abort", 8'h00, 8'h00, 8'h00, 2'd0);
    run(2);
    expect_out("h_emg_n", 8'h03, 8'h00, 8'h00, 2'd2);
    emgSignal = 1'b0; run(4);
    expect_out("h_emg_n_end", 8'h00, 8'h03, 8'h00, 2'd0);
    run(5);
    expect_out("h_ped_again", 8'h00, 8'h00, 8'hFF, 2'd3);
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 99) == 0) hoursIn = 5'($urandom_range(0, 31));
      pedSignal = $urandom_range(0, 39) == 0;
      emgSignal = emgSignal ? $urandom_range(0, 19) != 0 : $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 29) == 0)
        emgLane = $urandom_range(0, 3) == 0 ? 8'h00 : $urandom_range(0, 1) == 0 ?
                  8'h01 << $urandom_range(0, 7) : 8'($urandom);
      if ($urandom_range(0, 39) == 0)
        for (int b = 0; b < 8; b++)
          lanes[8*b +: 8] = $urandom_range(0, 2) == 0 ? 8'h00 : $urandom_range(0, 3) == 0 ?
                            8'hFF : 8'($urandom_range(0, 7));
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lane_phase_arbiter.md
# lane_phase_arbiter

- Decides which approach (W, S, E, N) of the intersection receives green, from the per-lane car counts on the shared 64-bit lane bus.
- Preempts normal operation for emergency vehicles and queues pedestrian walk requests.
- Owns the full green/yellow/all-red sequence with an internal phase timer.
- Sits between the Breadboard inputs (hoursIn, pedSignal, emgSignal, emgLane, lanes) and the light drivers (dayTimeLightOutput, walkingLightOutput); outputs are in the same lane bit order as the lane bus.

## Interface
Parameters:
- GREEN_DAY, 20, green length in cycles, day mode
- GREEN_NIGHT, 10, green length in cycles, night mode
- YELLOW_T, 3, yellow clearance length in cycles
- ALLRED_T, 2, all-red length in cycles
- PED_T, 8, walk length in cycles
- EMG_HOLD, 4, cycles the emergency green is held after emgSignal drops
- All parameters must be in the range 1..255.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets)
- hoursIn  in  5  hour of day, 0..23
- pedSignal  in  1  pedestrian request; a one-cycle pulse is enough
- emgSignal  in  1  emergency active
- emgLane  in  8  lane of the emergency vehicle, one-hot, lane bit order
- lanes  in  64  car counts {w1,w2,s1,s2,e1,e2,n1,n2}; w1=[63:56], n2=[7:0]
- greenMask  out  8  per-lane green; bit7=w1, bit6=w2, bit5=s1, bit4=s2, bit3=e1, bit2=e2, bit1=n1, bit0=n2
- yellowMask  out  8  per-lane yellow, same bit order
- walkMask  out  8  pedestrian walk lights
- trafficMode  out  2  00 day, 01 night, 10 emergency, 11 pedestrian
- phase  out  2  current approach: 0=W, 1=S, 2=E, 3=N
- currentCount  out  8  phase timer value

## Operation
- **Approaches.**
  - W = bits 7:6, S = 5:4, E = 3:2, N = 1:0.
  - Demand of an approach = zero-extended 9-bit sum of its two lane counts.
  - Green or yellow always drives both bits of one approach.
- **Night mode.** night = (hoursIn < 6) or (hoursIn >= 20); values above 23 count as night.
- **States:** ALLRED, GREEN, YELLOW, PED, EMG.
  - ALLRED: all masks 0.
  - GREEN: greenMask = the approach's two bits.
  - YELLOW: yellowMask = the approach's two bits.
  - PED: walkMask = 8'hFF, vehicle masks 0.
  - EMG: greenMask = the emergency approach's two bits.
- **Timer.**
  - On state entry the timer loads T-1, then decrements once per cycle.
  - The state exits on the cycle after the timer reaches 0, so each state lasts exactly T cycles.
- **Transitions.**
  - GREEN -> YELLOW -> ALLRED.
  - At the end of ALLRED, the first matching rule applies:
    1. Emergency request pending -> EMG.
    2. pedPending -> PED.
    3. Otherwise -> GREEN of the arbitrated approach.
  - PED -> ALLRED.
- **Arbitration** (sampled on the last ALLRED cycle):
  - Day: choose the largest demand among the three approaches other than `phase`. Ties go to the first approach in rotation order after `phase` (W->S->E->N->W). If all three demands are 0, take the next approach in rotation.
  - Night: always take the next approach in rotation; demand is ignored.
- **Pedestrian.**
  - pedSignal sets sticky pedPending.
  - pedPending clears on entry to PED.
- **Emergency request** = emgSignal=1 and emgLane != 0.
  - If several emgLane bits are set, the highest set bit wins.
  - In GREEN:
    - Same approach: go to EMG directly, with no yellow.
    - Different approach: go to YELLOW (full YELLOW_T), then ALLRED, then EMG.
  - In YELLOW or ALLRED: finish the sequence, then enter EMG.
  - In PED: abort immediately to ALLRED and set pedPending again.
  - In EMG:
    - The timer is held at EMG_HOLD-1 while the request stays active.
    - When the request drops, count down EMG_HOLD cycles, then go to YELLOW.
    - A new request during the countdown reloads the hold.
    - If emgLane moves to another approach: YELLOW -> ALLRED -> EMG for the new approach.
  - `phase` takes the emergency approach on EMG entry; arbitration afterwards excludes that approach.
- **trafficMode.**
  - EMG = 10, PED = 11.
  - All other states: 01 if night, else 00. Sampled each cycle.

## Timing
- **Reset** (rst=0 at a rising edge):
  - state ALLRED, timer ALLRED_T-1, phase=3 (N).
  - pedPending=0; greenMask, yellowMask and walkMask all 0.
  - trafficMode=00, currentCount=ALLRED_T-1.
- **Reset mid-operation:** the same values apply on the next edge, from any state, including EMG.
- **Registered outputs:** all outputs are registered and change on the same edge as the state register.
- **Input latency:** inputs are sampled on an edge and take effect on the outputs at that same edge, one cycle after they are applied.
- **Emergency latency in GREEN:** yellow (or EMG, for the same approach) appears on the edge after emgSignal is first seen high.
- **Simultaneous pedSignal and emergency:** the emergency is served first; pedPending stays set.
- **Simultaneous timer expiry and emergency in GREEN:** the emergency path applies; the normal path is not taken.

## Test plan
- **Reset and idle rotation:** rst=0 for 2 cycles, hoursIn=12, all lanes 0 -> masks 0, trafficMode=00; after ALLRED_T=2 cycles greenMask=8'hC0 (W) for 20 cycles, then yellowMask=8'hC0 for 3 cycles, then all-red 2 cycles, then greenMask=8'h30 (S).
- **Demand arbitration:** s1=8'h7F, n1=8'h07, others 0, starting from W green -> next green 8'h30 (S), then 8'h03 (N), then 8'h30 (S).
- **Tie-break:** from S green, e1=n1=5 -> E chosen (greenMask=8'h0C).
- **Emergency:** during W green, emgSignal=1, emgLane=8'b00001000:
  - yellowMask=8'hC0 on the next edge for 3 cycles, then all-red 2 cycles.
  - Then greenMask=8'h0C with trafficMode=10, held while emgSignal stays high.
  - Drop emgSignal -> green continues 4 more cycles, then yellowMask=8'h0C.
  - Assert rst=0 mid-EMG -> reset values on the next edge.
- **Pedestrian:** one-cycle pedSignal during green -> after yellow and all-red, walkMask=8'hFF and trafficMode=11 for 8 cycles, then all-red, then arbitrated green.
- **Night:** hoursIn=22, s1=8'hFF -> trafficMode=01; greens rotate W, S, E, N in order, each 10 cycles, ignoring demand.
